// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - opcodes, instruction layout and FSM encoding for alu_issue
package alu_issue_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADC  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SBC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_INC  = 4'b1101;
  localparam logic [3:0] OP_DEC  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RA_LSB  = 8;
  localparam int unsigned RB_LSB  = 6;
  localparam int unsigned IMM_BIT = 5;
  localparam int unsigned IMM_LSB = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       use_imm;
    logic [4:0] imm5;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WB    = 2'b10
  } state_e;

  function automatic logic [DATA_W-1:0] ext_imm5(input logic [4:0] imm, input logic sext);
    return sext ? {{11{imm[4]}}, imm} : {11'b0, imm};
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - 4x16 register file, r0 hardwired to zero, 1W/3R
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [1:0]        rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic [1:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [4];

  // Entry 0 is never written; reads of address 0 are forced to zero below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 2'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = (ra_addr_i  == 2'd0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o  = (rb_addr_i  == 2'd0) ? '0 : regs_q[rb_addr_i];
  assign dbg_data_o = (dbg_addr_i == 2'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - three-state issue/writeback sequencer feeding an external ALU
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter bit IMM_SEXT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c,
  input  logic              alu_s,
  input  logic              alu_o,
  input  logic              alu_z,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [3:0]        flags,
  output logic              done
);

  state_e            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              alu_cin_q, alu_cin_d;
  logic [3:0]        flags_q, flags_d;
  logic              done_q, done_d;
  logic              rf_we;
  logic [DATA_W-1:0] rf_ra_data, rf_rb_data;

  alu_issue_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (instr_q.rd),
    .wdata_i    (alu_out),
    .ra_addr_i  (instr_q.ra),
    .ra_data_o  (rf_ra_data),
    .rb_addr_i  (instr_q.rb),
    .rb_data_o  (rf_rb_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // done is registered so it rises together with the committed register/flag write.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    instr_d   = instr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    alu_cin_d = alu_cin_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) instr_d = instr_t'(in_instr);
      end
      ST_ISSUE: begin
        alu_a_d   = rf_ra_data;
        alu_b_d   = instr_q.use_imm ? ext_imm5(instr_q.imm5, IMM_SEXT) : rf_rb_data;
        alu_sel_d = instr_q.op;
        alu_cin_d = flags_q[3];
      end
      ST_WB: begin
        rf_we   = (instr_q.op != OP_CMP);
        flags_d = {alu_c, alu_s, alu_o, alu_z};
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      alu_cin_q <= 1'b0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      alu_cin_q <= alu_cin_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign alu_cin = alu_cin_q;
  assign flags   = flags_q;
  assign done    = done_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural ALU and ISA model
module tb_alu_issue;

  localparam bit IMM_SEXT_TB = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_cin, alu_c, alu_s, alu_o, alu_z;
  logic [1:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [3:0]  flags;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc = 0;

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [3:0]       sel;
    logic             cin;
    logic [3:0]       fl;
    logic [3:0][15:0] regs;
    int               acc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_r [4];
  logic [3:0]  m_fl;

  alu_issue #(.IMM_SEXT(IMM_SEXT_TB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin), .alu_out(alu_out),
    .alu_c(alu_c), .alu_s(alu_s), .alu_o(alu_o), .alu_z(alu_z),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flags(flags), .done(done)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {result, C, S, O, Z}.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, o;
    w = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'h0: w = {1'b0, a} + {1'b0, b};
      4'h1: w = {1'b0, a} + {1'b0, b} + 17'(cin);
      4'h2, 4'hC: w = {1'b0, a} + {1'b0, ~b} + 17'd1;
      4'h3: w = {1'b0, a} + {1'b0, ~b} + 17'(cin);
      4'h4: w = {1'b0, a & b};
      4'h5: w = {1'b0, a | b};
      4'h6: w = {1'b0, a ^ b};
      4'h7: w = {1'b0, ~a};
      4'h8: w = {a, 1'b0};
      4'h9: w = {a[0], 1'b0, a[15:1]};
      4'hA: w = {a[0], a[15], a[15:1]};
      4'hD: w = {1'b0, a} + 17'd1;
      4'hE: w = {1'b0, a} + 17'h0ffff;
      default: w = {1'b0, b};
    endcase
    r = w[15:0];
    c = w[16];
    case (op)
      4'h0, 4'h1: o = (a[15] == b[15]) && (r[15] != a[15]);
      4'h2, 4'h3, 4'hC: o = (a[15] != b[15]) && (r[15] != a[15]);
      4'hD: o = (a == 16'h7fff);
      4'hE: o = (a == 16'h8000);
      default: o = 1'b0;
    endcase
    return {r, c, r[15], o, (r == 16'h0)};
  endfunction

  always_comb {alu_out, alu_c, alu_s, alu_o, alu_z} = alu_fn(alu_sel, alu_a, alu_b, alu_cin);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb,
                                     input int ui, input int imm);
    return {4'(op), 2'(rd), 2'(ra), 2'(rb), 1'(ui), 5'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
    m_fl = 4'h0;
  endtask

  task automatic push_model(input logic [15:0] ins, input int acc);
    exp_t        e;
    logic [19:0] res;
    logic [15:0] ext;
    ext   = IMM_SEXT_TB ? {{11{ins[4]}}, ins[4:0]} : {11'b0, ins[4:0]};
    e.a   = m_r[ins[9:8]];
    e.b   = ins[5] ? ext : m_r[ins[7:6]];
    e.sel = ins[15:12];
    e.cin = m_fl[3];
    res   = alu_fn(e.sel, e.a, e.b, e.cin);
    if (ins[15:12] != 4'hC && ins[11:10] != 2'd0) m_r[ins[11:10]] = res[19:4];
    m_fl   = res[3:0];
    e.fl   = m_fl;
    e.regs = {m_r[3], m_r[2], m_r[1], m_r[0]};
    e.acc  = acc;
    sbq.push_back(e);
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic issue(input logic [15:0] ins, input bit keep, input bit model);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        last_acc = cyc + 1;
        if (model) push_model(ins, cyc + 1);
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_low_issue", 32'(in_ready), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    #2;
  endtask

  task automatic rd_dbg(input logic [1:0] addr, output logic [15:0] val);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("latency", 32'(cyc - e.acc), 32'd2);
        chk("alu_a", 32'(alu_a), 32'(e.a));
        chk("alu_b", 32'(alu_b), 32'(e.b));
        chk("alu_sel", 32'(alu_sel), 32'(e.sel));
        chk("alu_cin", 32'(alu_cin), 32'(e.cin));
        chk("flags", 32'(flags), 32'(e.fl));
        for (int i = 0; i < 4; i++) begin
          dbg_addr = 2'(i);
          #1;
          chk($sformatf("reg_r%0d", i), 32'(dbg_data), 32'(e.regs[i]));
        end
      end
    end
  end

  initial begin
    #300000;
    chk("global_timeout", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [15:0] v;
    int          a0;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; dbg_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_alu_cin", 32'(alu_cin), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rd_dbg(2'd3, v);
    chk("rst_r3", 32'(v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    issue(mk(0, 1, 0, 0, 1, 5), 0, 1); drain();
    issue(mk(0, 2, 0, 0, 1, 3), 0, 1); drain();
    rd_dbg(2'd1, v); chk("load_r1", 32'(v), 32'h0005);
    rd_dbg(2'd2, v); chk("load_r2", 32'(v), 32'h0003);
    issue(mk(2, 3, 1, 2, 0, 0), 0, 1); drain();
    rd_dbg(2'd3, v); chk("sub_r3", 32'(v), 32'h0002);
    chk("sub_z", 32'(flags[0]), 32'd0);
    issue(mk(12, 1, 1, 1, 0, 0), 0, 1); drain();
    rd_dbg(2'd1, v); chk("cmp_r1_kept", 32'(v), 32'h0005);
    chk("cmp_z", 32'(flags[0]), 32'd1);
    issue(mk(7, 1, 0, 0, 0, 0), 0, 1); drain();
    rd_dbg(2'd1, v); chk("not_r1", 32'(v), 32'hffff);
    issue(mk(0, 2, 1, 0, 1, 1), 0, 1); drain();
    rd_dbg(2'd2, v); chk("wrap_r2", 32'(v), 32'h0000);
    chk("wrap_flags", 32'(flags), 32'b1001);
    issue(mk(1, 3, 0, 0, 1, 0), 0, 1); drain();
    chk("adc_cin", 32'(alu_cin), 32'd1);
    rd_dbg(2'd3, v); chk("adc_r3", 32'(v), 32'h0001);
    issue(mk(0, 0, 0, 0, 1, 7), 0, 1); drain();
    rd_dbg(2'd0, v); chk("r0_zero", 32'(v), 32'h0000);

    a0 = acc_cnt;
    issue(mk(0, 1, 1, 0, 1, 2), 1, 1);
    v = 16'(last_acc);
    issue(mk(6, 2, 1, 3, 0, 0), 1, 1);
    issue(mk(13, 3, 2, 0, 0, 0), 0, 1);
    drain();
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd3);
    chk("b2b_spacing", 32'(last_acc - int'(v)), 32'd6);

    for (int n = 0; n < 60; n++) begin
      issue(16'($urandom), 1'($urandom_range(0, 1)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

    issue(mk(0, 1, 0, 0, 1, 9), 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    rd_dbg(2'd1, v); chk("abort_r1", 32'(v), 32'h0000);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);

    issue(mk(0, 2, 0, 0, 1, 4), 0, 1); drain();
    rd_dbg(2'd2, v); chk("post_abort_r2", 32'(v), 32'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: IMM_SEXT, 0, when 1 imm5 is sign-extended to 16 bits, otherwise zero-extended.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  instruction word valid.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 in_instr  input  16  [15:12] op, [11:10] rd, [9:8] ra, [7:6] rb, [5] use_imm, [4:0] imm5.
REQ-007 alu_a / alu_b  output  16 each  ALU operands.
REQ-008 alu_sel  output  4  ALU operation select; op field passed through unchanged.
REQ-009 alu_cin  output  1  carry-in, driven from stored C flag.
REQ-010 alu_out  input  16  ALU registered result.
REQ-011 alu_c, alu_s, alu_o, alu_z  input  1 each  ALU carry, sign, overflow, zero flags.
REQ-012 dbg_addr  input  2  debug register read address; dbg_data  output  16  register contents, combinational.
REQ-013 flags  output  4  stored {C,S,O,Z}.
REQ-014 done  output  1  one-cycle pulse when an instruction retires.

Function
REQ-015 Register file: four 16-bit registers r0..r3; r0 always reads 0x0000; writes to r0 are discarded.
REQ-016 FSM states: IDLE, ISSUE, WB; in_ready = 1 only in IDLE.
REQ-017 IDLE: on in_valid & in_ready, latch in_instr and go to ISSUE; otherwise stay.
REQ-018 ISSUE: register alu_a = R[ra], alu_b = use_imm ? ext(imm5) : R[rb], alu_sel = op, alu_cin = C; go to WB.
REQ-019 alu_a, alu_b, alu_sel and alu_cin are registers and hold their values until the next ISSUE.
REQ-020 ALU result is sampled on the cycle after the operands become valid, so the sample is taken at the end of WB.
REQ-021 WB: write alu_out to R[rd] unless op = 4'b1100 (compare); capture {alu_c,alu_s,alu_o,alu_z} into flags for every op; assert done; go to IDLE.
REQ-022 Latency: accept edge to done = 2 cycles; throughput one instruction per 3 cycles.
REQ-023 in_valid while in_ready = 0 is ignored; the source holds the instruction until accepted.
REQ-024 Register read for ISSUE uses values written by the previous WB; no forwarding hazard exists.
REQ-025 All arithmetic is 16-bit modulo; the block does not recompute flags.

Reset
REQ-026 On rst_n low: state = IDLE, r1..r3 = 0, flags = 0, alu_a = alu_b = 0, alu_sel = 0, alu_cin = 0, done = 0, latched instr = 0.
REQ-027 Reset asserted in ISSUE or WB aborts the instruction; no register or flag write occurs.
REQ-028 After rst_n release, in_ready = 1 in the first cycle.

Structure
REQ-029 Shared package holds the opcode constants (ADD 0000 ... DEC 1110, PASS default), the instruction field positions, and the FSM state encoding.
REQ-030 Register file is a sub-module alu_issue_regfile: one write port, three combinational read ports (ra, rb, dbg).

Verification
REQ-031 Load: ADD r1,r0,#5, then ADD r2,r0,#3 -> r1 = 0x0005, r2 = 0x0003, done pulses 2 cycles after each accept.
REQ-032 SUB r3,r1,r2 -> r3 = 0x0002, Z = 0; CMP r1,r1 -> r1 unchanged, flags Z = 1.
REQ-033 NOT r1,r0 -> r1 = 0xFFFF; ADD r2,r1,#1 -> r2 = 0x0000, C = 1, Z = 1; ADC r3,r0,#0 -> alu_cin = 1, r3 = 0x0001.
REQ-034 Write to r0 (ADD r0,r0,#7) -> dbg read of r0 = 0x0000, done still pulses.
REQ-035 in_valid held high for 9 cycles with three different instructions presented back-to-back -> exactly three accepts, in_ready low in ISSUE and WB.
REQ-036 Assert rst_n low during the WB of ADD r1,r0,#9 -> r1 = 0x0000 and flags = 0 after reset, no done pulse.
